// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_buffer
//   Queues committed stores from the MEM stage and drains them, oldest first,
//   to the data-memory write port over a req/ack handshake. Store data is
//   replicated into the byte lanes selected by funct3M; the byte enables come
//   from the upstream byte-enable generator. The pipeline is stalled when the
//   buffer is full, when a load hits a pending store's word address, and on a
//   fence until the buffer has fully drained.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   MemWriteM/MemReadM      store / load in the MEM stage
//   fenceM                  fence in the MEM stage
//   ALUResultM              store/load byte address
//   WriteDataM, funct3M     raw rs2 data and access size (000 sb, 001 sh)
//   byteEnableM             lane enables for the store
//   StallSB                 combinational pipeline stall request
//   memReq/Addr/WData/BE    registered memory write request
//   memAck                  memory accepted the current request
//   sbEmpty                 nothing queued and nothing in flight
//   sbCount                 valid entries, head in flight included
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       MemWriteM,
  input  logic                       MemReadM,
  input  logic                       fenceM,
  input  logic [ADDR_W-1:0]          ALUResultM,
  input  logic [XLEN-1:0]            WriteDataM,
  input  logic [2:0]                 funct3M,
  input  logic [XLEN/8-1:0]          byteEnableM,
  output logic                       StallSB,
  output logic                       memReq,
  output logic [ADDR_W-1:0]          memAddr,
  output logic [XLEN-1:0]            memWData,
  output logic [XLEN/8-1:0]          memBE,
  input  logic                       memAck,
  output logic                       sbEmpty,
  output logic [$clog2(DEPTH+1)-1:0] sbCount
);

  localparam int BE_W  = XLEN / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Clears the byte-offset bits so every compare and request is word aligned.
  localparam logic [ADDR_W-1:0] WA_MASK = ~ADDR_W'(BE_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Replicate the low byte / halfword across the word so any enabled lane
  // carries the right value; wider accesses pass through untouched.
  function automatic logic [XLEN-1:0] place_data(input logic [2:0]      f3,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = d;
    case (f3)
      3'b000: begin
        for (int i = 0; i < XLEN / 8; i++) r[i*8 +: 8] = d[7:0];
      end
      3'b001: begin
        for (int i = 0; i < XLEN / 16; i++) r[i*16 +: 16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [XLEN-1:0]   data_mem_r [DEPTH];
  logic [BE_W-1:0]   be_mem_r   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  state_t            state_r;

  logic [ADDR_W-1:0] wa_s;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              hazard_s;

  assign wa_s     = ALUResultM & WA_MASK;
  assign rd_nxt_s = rd_ptr_r + PTR_W'(1);
  // Full is judged on the registered count only, so a same-cycle ack never
  // lets a store slip in.
  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign push_s   = MemWriteM && (byteEnableM != {BE_W{1'b0}}) && !full_s;
  assign pop_s    = memReq && memAck;

  // Load hazard: compare the load word address against every live slot.
  always_comb begin
    logic [PTR_W-1:0] off_v;
    hazard_s = 1'b0;
    off_v    = {PTR_W{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      // Distance from the head tells whether slot j currently holds a store.
      off_v = PTR_W'(j) - rd_ptr_r;
      if ((CNT_W'(off_v) < count_r) && (addr_mem_r[j] == wa_s)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign sbEmpty = (count_r == {CNT_W{1'b0}}) && (state_r == IDLE);
  assign sbCount = count_r;
  assign StallSB = (MemWriteM && full_s) | (MemReadM && hazard_s) | (fenceM && !sbEmpty);

  // Entry storage, ring pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
        addr_mem_r[j] <= {ADDR_W{1'b0}};
        data_mem_r[j] <= {XLEN{1'b0}};
        be_mem_r[j]   <= {BE_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= wa_s;
        data_mem_r[wr_ptr_r] <= place_data(funct3M, WriteDataM);
        be_mem_r[wr_ptr_r]   <= byteEnableM;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM driving the registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      memReq   <= 1'b0;
      memAddr  <= {ADDR_W{1'b0}};
      memWData <= {XLEN{1'b0}};
      memBE    <= {BE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != {CNT_W{1'b0}}) begin
            memAddr  <= addr_mem_r[rd_ptr_r];
            memWData <= data_mem_r[rd_ptr_r];
            memBE    <= be_mem_r[rd_ptr_r];
            memReq   <= 1'b1;
            state_r  <= BUSY;
          end else begin
            memReq <= 1'b0;
          end
        end
        BUSY: begin
          if (memAck) begin
            if (count_r > CNT_W'(1)) begin
              // Next head goes out on the same edge: back-to-back beats.
              memAddr  <= addr_mem_r[rd_nxt_s];
              memWData <= data_mem_r[rd_nxt_s];
              memBE    <= be_mem_r[rd_nxt_s];
            end else begin
              memReq  <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          memReq  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
module tb_store_buffer;
  localparam int XLEN = 32, DEPTH = 4, ADDR_W = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic MemWriteM, MemReadM, fenceM, memAck;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  funct3M;
  logic [3:0]  byteEnableM;
  logic        StallSB, memReq, sbEmpty;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memBE;
  logic [2:0]  sbCount;

  int pass_cnt = 0, total_cnt = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } ent_t;

  store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .fenceM(fenceM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .funct3M(funct3M), .byteEnableM(byteEnableM), .StallSB(StallSB),
    .memReq(memReq), .memAddr(memAddr), .memWData(memWData), .memBE(memBE),
    .memAck(memAck), .sbEmpty(sbEmpty), .sbCount(sbCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected lane placement written straight from the access-size rules.
  function automatic logic [31:0] ref_place(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'b000) return {4{d[7:0]}};
    else if (f == 3'b001) return {2{d[15:0]}};
    else return d;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    MemWriteM = 1'b0; MemReadM = 1'b0; fenceM = 1'b0; memAck = 1'b0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; funct3M = 3'b000; byteEnableM = 4'h0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f, input logic [3:0] be);
    MemWriteM = 1'b1; ALUResultM = a; WriteDataM = d; funct3M = f; byteEnableM = be;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (memReq !== 1'b0) $display("FAIL rst_memReq: got %b want 0", memReq); else pass_cnt++;
    total_cnt++; if (memAddr !== 32'h0) $display("FAIL rst_memAddr: got %h want 0", memAddr); else pass_cnt++;
    total_cnt++; if (memWData !== 32'h0) $display("FAIL rst_memWData: got %h want 0", memWData); else pass_cnt++;
    total_cnt++; if (memBE !== 4'h0) $display("FAIL rst_memBE: got %b want 0", memBE); else pass_cnt++;
    total_cnt++; if (sbEmpty !== 1'b1) $display("FAIL rst_sbEmpty: got %b want 1", sbEmpty); else pass_cnt++;
    total_cnt++; if (sbCount !== 3'd0) $display("FAIL rst_sbCount: got %0d want 0", sbCount); else pass_cnt++;
    rst_n = 1'b1;
    cyc(); #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL rst_stall: got %b want 0", StallSB); else pass_cnt++;
    cyc();
  endtask

  task automatic test_sb();
    drive_store(32'h1003, 32'hA5, 3'b000, 4'b1000); #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL sb_stall: got %b want 0", StallSB); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (memReq !== 1'b0) $display("FAIL sb_req_n1: got %b want 0", memReq); else pass_cnt++;
    total_cnt++; if (sbCount !== 3'd1) $display("FAIL sb_count_n1: got %0d want 1", sbCount); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (memReq !== 1'b1) $display("FAIL sb_req_n2: got %b want 1", memReq); else pass_cnt++;
    total_cnt++; if (memAddr !== 32'h1000) $display("FAIL sb_addr: got %h want 00001000", memAddr); else pass_cnt++;
    total_cnt++; if (memWData !== 32'hA5A5A5A5) $display("FAIL sb_data: got %h want a5a5a5a5", memWData); else pass_cnt++;
    total_cnt++; if (memBE !== 4'b1000) $display("FAIL sb_be: got %b want 1000", memBE); else pass_cnt++;
    memAck = 1'b1;
    cyc(); memAck = 1'b0; #1;
    total_cnt++; if (memReq !== 1'b0) $display("FAIL sb_req_after_ack: got %b want 0", memReq); else pass_cnt++;
    total_cnt++; if (sbEmpty !== 1'b1) $display("FAIL sb_empty: got %b want 1", sbEmpty); else pass_cnt++;
    cyc();
  endtask

  task automatic test_sh_and_drop();
    drive_store(32'h2002, 32'h1234BEEF, 3'b001, 4'b1100);
    cyc(); idle(); cyc(); #1;
    total_cnt++; if (memReq !== 1'b1) $display("FAIL sh_req: got %b want 1", memReq); else pass_cnt++;
    total_cnt++; if (memAddr !== 32'h2000) $display("FAIL sh_addr: got %h want 00002000", memAddr); else pass_cnt++;
    total_cnt++; if (memWData !== 32'hBEEFBEEF) $display("FAIL sh_data: got %h want beefbeef", memWData); else pass_cnt++;
    total_cnt++; if (memBE !== 4'b1100) $display("FAIL sh_be: got %b want 1100", memBE); else pass_cnt++;
    memAck = 1'b1;
    cyc(); memAck = 1'b0;
    // A store with no enabled lanes is dropped without a stall.
    drive_store(32'h2100, 32'hFFFFFFFF, 3'b010, 4'b0000); #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL drop_stall: got %b want 0", StallSB); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (sbCount !== 3'd0) $display("FAIL drop_count: got %0d want 0", sbCount); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (memReq !== 1'b0) $display("FAIL drop_req: got %b want 0", memReq); else pass_cnt++;
    cyc();
  endtask

  task automatic test_full();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    int b;
    logic done;
    memAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h4000 + 32'(4 * i), 32'h11110000 + 32'(i), 3'b010, 4'hF);
      cyc();
    end
    drive_store(32'h4010, 32'h5555AAAA, 3'b010, 4'hF); #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL full_stall: got %b want 1", StallSB); else pass_cnt++;
    total_cnt++; if (sbCount !== 3'd4) $display("FAIL full_count: got %0d want 4", sbCount); else pass_cnt++;
    memAck = 1'b1; #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL full_stall_same_ack: got %b want 1", StallSB); else pass_cnt++;
    cyc(); memAck = 1'b0; #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL full_release: got %b want 0", StallSB); else pass_cnt++;
    total_cnt++; if (sbCount !== 3'd3) $display("FAIL full_count_after_ack: got %0d want 3", sbCount); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (sbCount !== 3'd4) $display("FAIL full_wrap_count: got %0d want 4", sbCount); else pass_cnt++;
    exp_a[0] = 32'h4004; exp_a[1] = 32'h4008; exp_a[2] = 32'h400C; exp_a[3] = 32'h4010;
    exp_d[0] = 32'h11110001; exp_d[1] = 32'h11110002; exp_d[2] = 32'h11110003; exp_d[3] = 32'h5555AAAA;
    b = 0; done = 1'b0;
    memAck = 1'b1;
    for (int c = 0; c < 12 && !done; c++) begin
      #1;
      if (memReq) begin
        if (b < 4) begin
          total_cnt++; if (memAddr !== exp_a[b] || memWData !== exp_d[b])
            $display("FAIL full_drain_beat%0d: got %h/%h want %h/%h", b, memAddr, memWData, exp_a[b], exp_d[b]);
          else pass_cnt++;
        end else begin
          total_cnt++; $display("FAIL full_extra_beat: got beat %0d want at most 4", b);
        end
        b++;
      end
      if (sbEmpty) done = 1'b1;
      cyc();
    end
    memAck = 1'b0;
    total_cnt++; if (b != 4 || !done) $display("FAIL full_drain_total: got %0d beats empty=%b want 4 beats empty=1", b, done); else pass_cnt++;
  endtask

  task automatic test_hazard();
    drive_store(32'h3000, 32'hCAFEF00D, 3'b010, 4'hF);
    cyc(); idle(); cyc();
    MemReadM = 1'b1; ALUResultM = 32'h3001; #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL haz_same_word: got %b want 1", StallSB); else pass_cnt++;
    ALUResultM = 32'h3004; #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL haz_other_word: got %b want 0", StallSB); else pass_cnt++;
    ALUResultM = 32'h3001; memAck = 1'b1; #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL haz_until_ack: got %b want 1", StallSB); else pass_cnt++;
    cyc(); memAck = 1'b0; #1;
    total_cnt++; if (StallSB !== 1'b0) $display("FAIL haz_after_ack: got %b want 0", StallSB); else pass_cnt++;
    idle(); cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h6000 + 32'(8 * i), $urandom, 3'b010, 4'hF);
      cyc();
    end
    idle(); cyc();
    memAck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 3) begin
        total_cnt++; if (memReq !== 1'b1 || memAddr !== 32'h6000 + 32'(8 * k))
          $display("FAIL b2b_beat%0d: got req=%b addr=%h want req=1 addr=%h", k, memReq, memAddr, 32'h6000 + 32'(8 * k));
        else pass_cnt++;
      end else begin
        total_cnt++; if (memReq !== 1'b0 || sbEmpty !== 1'b1)
          $display("FAIL b2b_end: got req=%b empty=%b want req=0 empty=1", memReq, sbEmpty);
        else pass_cnt++;
      end
      cyc();
    end
    memAck = 1'b0;
  endtask

  task automatic test_fence();
    drive_store(32'h7000, 32'h01020304, 3'b010, 4'hF); cyc();
    drive_store(32'h7004, 32'h05060708, 3'b010, 4'hF); cyc();
    idle(); cyc();
    fenceM = 1'b1; #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL fence_two: got %b want 1", StallSB); else pass_cnt++;
    memAck = 1'b1;
    cyc(); #1;
    total_cnt++; if (StallSB !== 1'b1) $display("FAIL fence_one: got %b want 1", StallSB); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (StallSB !== 1'b0 || sbEmpty !== 1'b1)
      $display("FAIL fence_drained: got stall=%b empty=%b want stall=0 empty=1", StallSB, sbEmpty);
    else pass_cnt++;
    idle(); cyc();
  endtask

  task automatic test_reset_mid();
    drive_store(32'h8000, 32'h9ABCDEF0, 3'b010, 4'hF); cyc();
    drive_store(32'h8004, 32'h13579BDF, 3'b010, 4'hF); cyc();
    idle(); cyc(); #1;
    total_cnt++; if (memReq !== 1'b1) $display("FAIL rstmid_pre_req: got %b want 1", memReq); else pass_cnt++;
    #1 rst_n = 1'b0; #1;
    total_cnt++; if (memReq !== 1'b0) $display("FAIL rstmid_req: got %b want 0", memReq); else pass_cnt++;
    total_cnt++; if (sbCount !== 3'd0) $display("FAIL rstmid_count: got %0d want 0", sbCount); else pass_cnt++;
    cyc(); rst_n = 1'b1; cyc(); cyc(); #1;
    total_cnt++; if (memReq !== 1'b0 || sbEmpty !== 1'b1)
      $display("FAIL rstmid_discard: got req=%b empty=%b want req=0 empty=1", memReq, sbEmpty);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic [31:0] a, d, wa_ld;
    logic [2:0]  f;
    logic [3:0]  be;
    logic haz, exp_stall, do_push, do_pop;
    int op;
    for (int c = 0; c < 400; c++) begin
      idle();
      op = $urandom_range(0, 9);
      memAck = 1'($urandom_range(0, 1));
      e.a = 32'h0; e.d = 32'h0; e.be = 4'h0;
      if (op <= 3) begin
        a = 32'h5000 + 32'($urandom_range(0, 31));
        d = $urandom;
        f = 3'($urandom_range(0, 3));
        if (f == 3'b000) be = 4'b0001 << a[1:0];
        else if (f == 3'b001) be = a[1] ? 4'b1100 : 4'b0011;
        else be = 4'hF;
        if ($urandom_range(0, 7) == 0) be = 4'h0;
        drive_store(a, d, f, be);
        e.a = {a[31:2], 2'b00}; e.d = ref_place(f, d); e.be = be;
      end else if (op <= 5) begin
        MemReadM = 1'b1;
        ALUResultM = 32'h5000 + 32'($urandom_range(0, 31));
      end else if (op == 6) begin
        fenceM = 1'b1;
      end
      #1;
      wa_ld = {ALUResultM[31:2], 2'b00};
      haz = 1'b0;
      foreach (q[i]) if (q[i].a == wa_ld) haz = 1'b1;
      exp_stall = (MemWriteM && q.size() == DEPTH) || (MemReadM && haz) || (fenceM && q.size() != 0);
      total_cnt++; if (StallSB !== exp_stall) $display("FAIL rand_stall c%0d: got %b want %b", c, StallSB, exp_stall); else pass_cnt++;
      total_cnt++; if (sbCount !== 3'(q.size())) $display("FAIL rand_count c%0d: got %0d want %0d", c, sbCount, q.size()); else pass_cnt++;
      total_cnt++; if (sbEmpty !== (q.size() == 0)) $display("FAIL rand_empty c%0d: got %b want %b", c, sbEmpty, q.size() == 0); else pass_cnt++;
      if (memReq) begin
        if (q.size() == 0) begin
          total_cnt++; $display("FAIL rand_spurious_req c%0d: got req=1 want 0", c);
        end else begin
          total_cnt++; if (memAddr !== q[0].a || memWData !== q[0].d || memBE !== q[0].be)
            $display("FAIL rand_head c%0d: got %h/%h/%b want %h/%h/%b", c, memAddr, memWData, memBE, q[0].a, q[0].d, q[0].be);
          else pass_cnt++;
        end
      end
      do_pop  = memReq && memAck && (q.size() > 0);
      do_push = MemWriteM && (byteEnableM != 4'h0) && (q.size() < DEPTH);
      cyc();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    idle();
    memAck = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      do_pop = 1'b0;
      if (memReq) begin
        total_cnt++; if (memAddr !== q[0].a || memWData !== q[0].d || memBE !== q[0].be)
          $display("FAIL rand_drain_head: got %h/%h/%b want %h/%h/%b", memAddr, memWData, memBE, q[0].a, q[0].d, q[0].be);
        else pass_cnt++;
        do_pop = 1'b1;
      end
      cyc();
      if (do_pop) void'(q.pop_front());
    end
    #1;
    total_cnt++; if (sbEmpty !== 1'b1 || q.size() != 0)
      $display("FAIL rand_drain_empty: got empty=%b left=%0d want empty=1 left=0", sbEmpty, q.size());
    else pass_cnt++;
    memAck = 1'b0;
    cyc();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sb();
    test_sh_and_drop();
    test_full();
    test_hazard();
    test_back_to_back();
    test_fence();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
